// File: rtl/vidq.sv
// Byte command FIFO feeding a 2D accelerator: each queued packet is copied into
// the accelerator command area in video memory, NUL-terminated, then kicked off.
module vidq #(
  parameter int          DEPTH_LOG = 8,
  parameter logic [17:0] ACMD      = 18'h20000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [7:0]           wd,
  input  logic                 flush,
  input  logic                 page_in,
  output logic                 full,
  output logic [DEPTH_LOG:0]   level,
  output logic                 ovf,
  output logic                 idle,
  output logic                 done,
  output logic [17:0]          ma,
  output logic [7:0]           mo,
  output logic                 mw,
  output logic                 own,
  output logic                 cmd,
  output logic                 page,
  input  logic                 bsy
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  typedef enum logic [2:0] {
    S_IDLE, S_COPY, S_TERM, S_KICK, S_WAITHI, S_WAITLO
  } state_t;

  logic [7:0]           mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] wp_q, rp_q;
  logic [DEPTH_LOG:0]   level_q;
  logic                 ovf_q;
  logic                 push_ok, pop;
  logic [7:0]           head;
  logic [3:0]           head_len;
  logic                 head_valid;

  state_t     state_q, state_d;
  logic [3:0] k_q, k_d, len_q, len_d;
  logic [1:0] wt_q, wt_d;
  logic       page_q, done_q;

  assign full    = (level_q == (DEPTH_LOG+1)'(DEPTH));
  assign push_ok = wr && !full && !flush;
  assign head    = mem_q[rp_q];

  // Invalid codes decode to a one-byte packet so they can be discarded alone.
  always_comb begin
    head_valid = 1'b1;
    case (head)
      8'd1, 8'd2, 8'd3: head_len = 4'd10;
      8'd4:             head_len = 4'd6;
      8'd5, 8'd6:       head_len = 4'd8;
      default: begin
        head_len   = 4'd1;
        head_valid = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      rp_q    <= wp_q;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wp_q <= wp_q + DEPTH_LOG'(1);
      if (pop)     rp_q <= rp_q + DEPTH_LOG'(1);
      level_q <= level_q + (DEPTH_LOG+1)'(push_ok) - (DEPTH_LOG+1)'(pop);
      if (wr && full) ovf_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers and level define validity,
  // and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wp_q] <= wd;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      len_q   <= '0;
      wt_q    <= '0;
      page_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
      wt_q    <= wt_d;
      done_q  <= (state_q == S_WAITLO) && !bsy;
      if (state_q == S_KICK) page_q <= page_in;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    wt_d    = wt_q;
    pop     = 1'b0;
    own     = 1'b0;
    mw      = 1'b0;
    ma      = '0;
    mo      = '0;
    cmd     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0 && !head_valid) begin
          pop = 1'b1;
        end else if (head_valid && level_q >= (DEPTH_LOG+1)'(head_len) && !bsy) begin
          len_d   = head_len;
          k_d     = '0;
          state_d = S_COPY;
        end
      end
      S_COPY: begin
        own = 1'b1;
        mw  = 1'b1;
        ma  = ACMD + {14'd0, k_q};
        mo  = head;
        pop = 1'b1;
        k_d = k_q + 4'd1;
        if (k_q == len_q - 4'd1) state_d = S_TERM;
      end
      S_TERM: begin
        own     = 1'b1;
        mw      = 1'b1;
        ma      = ACMD + {14'd0, len_q};
        state_d = S_KICK;
      end
      S_KICK: begin
        cmd     = 1'b1;
        wt_d    = '0;
        state_d = S_WAITHI;
      end
      S_WAITHI: begin
        if (bsy)               state_d = S_WAITLO;
        else if (wt_q == 2'd3) state_d = S_IDLE;
        else                   wt_d    = wt_q + 2'd1;
      end
      S_WAITLO: begin
        if (!bsy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A flush mid-transfer abandons the packet; a launched command runs on.
    if (flush && (state_q == S_COPY || state_q == S_TERM)) state_d = S_IDLE;
  end

  assign level = level_q;
  assign ovf   = ovf_q;
  assign idle  = (level_q == '0) && (state_q == S_IDLE);
  assign done  = done_q;
  assign page  = page_q;

endmodule
